// File: rtl/key_capture_pio_pkg.sv
// rtl/key_capture_pio_pkg.sv - register map, bus width and counter sizing for key_capture_pio
package key_capture_pio_pkg;

  localparam int         DATA_W       = 32;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_RELEASE = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  // Width that holds 0..cycles-1, i.e. ceil(log2(cycles)).
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_capture_pio_debounce.sv
// rtl/key_capture_pio_debounce.sv - key_debounce: one channel's synchroniser, polarity fix, counter and stable flop
module key_debounce
  import key_capture_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key,
  output logic o_stable,
  output logic o_rise_pulse,
  output logic o_fall_pulse
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;
  logic          w_accept;

  assign w_mismatch = r_sync ^ r_stable;
  assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

  // Polarity is fixed ahead of the flops so their reset value 0 means "released".
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_key ^ ACTIVE_LOW;
      r_sync <= r_meta;
      if (w_accept) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else if (w_mismatch) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable     = r_stable;
  assign o_rise_pulse = w_accept & r_sync;
  assign o_fall_pulse = w_accept & ~r_sync;

endmodule

// File: rtl/key_capture_pio.sv
// rtl/key_capture_pio.sv - debounced key PIO with press-edge flags and level irq
// Optional macro KEY_CAPTURE_PIO_RELEASE_EN adds the W1C RELEASE register at address 2.
module key_capture_pio
  import key_capture_pio_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [1:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                irq
);

  logic [NUM_KEYS-1:0] w_stable;
  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_fall;
  logic [NUM_KEYS-1:0] w_release;
  logic [NUM_KEYS-1:0] w_edge_clr;
  logic                w_wr_mask;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_unused;

  logic [NUM_KEYS-1:0] r_mask;
  logic [NUM_KEYS-1:0] r_edge;
  logic [DATA_W-1:0]   r_readdata;
  logic                r_irq;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_debounce (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_key       (key_in[g]),
      .o_stable    (w_stable[g]),
      .o_rise_pulse(w_rise[g]),
      .o_fall_pulse(w_fall[g])
    );
  end

  assign w_wr_mask  = avs_write && (avs_address == ADDR_IRQMASK);
  assign w_edge_clr = (avs_write && (avs_address == ADDR_EDGE)) ? avs_writedata[NUM_KEYS-1:0] : '0;

`ifdef KEY_CAPTURE_PIO_RELEASE_EN
  logic [NUM_KEYS-1:0] r_release;
  logic [NUM_KEYS-1:0] w_rel_clr;

  assign w_rel_clr = (avs_write && (avs_address == ADDR_RELEASE)) ? avs_writedata[NUM_KEYS-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_release <= '0;
    end else begin
      r_release <= (r_release & ~w_rel_clr) | w_fall;
    end
  end

  assign w_release = r_release;
  assign w_unused  = ^avs_writedata;
`else
  assign w_release = '0;
  assign w_unused  = ^{avs_writedata, w_fall};
`endif

  always_comb begin
    w_rd_data = '0;
    case (avs_address)
      ADDR_DATA:    w_rd_data[NUM_KEYS-1:0] = w_stable;
      ADDR_IRQMASK: w_rd_data[NUM_KEYS-1:0] = r_mask;
      ADDR_RELEASE: w_rd_data[NUM_KEYS-1:0] = w_release;
      default:      w_rd_data[NUM_KEYS-1:0] = r_edge;
    endcase
  end

  // Set terms are OR-ed after the clear so a coincident press survives a W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask     <= '0;
      r_edge     <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (avs_read) begin
        r_readdata <= w_rd_data;
      end
      if (w_wr_mask) begin
        r_mask <= avs_writedata[NUM_KEYS-1:0];
      end
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
      r_irq  <= |((r_edge | w_release) & r_mask);
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_key_capture_pio.sv
// tb/tb_key_capture_pio.sv - directed self-checking bench for key_capture_pio (4 keys, 8-cycle debounce, active-low)
module tb_key_capture_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_in;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  key_capture_pio #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    step();
    avs_read = 1'b0;
    d        = avs_readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic clear_all();
    wr(2'd1, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    settle(2);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    key_in = 4'hF;
    settle(3);
    total_cnt++;
    if (avs_readdata !== 32'h0) $display("FAIL reset_readdata: got %h expected %h", avs_readdata, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else pass_cnt++;
    reset = 1'b0;
    settle(3);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL reset_reg%0d: got %h expected %h", a, d, 32'h0);
      else pass_cnt++;
    end
  endtask

  task automatic test_press();
    logic [31:0] d;
    wr(2'd1, 32'h4);
    key_in[2] = 1'b0;
    avs_address = 2'd0;
    avs_read    = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 10) begin
        total_cnt++;
        if (avs_readdata !== 32'h0) $display("FAIL press_data_early: got %h expected %h", avs_readdata, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL press_irq_early: got %b expected 0", irq);
        else pass_cnt++;
      end
      if (i == 11) begin
        total_cnt++;
        if (avs_readdata !== 32'h4) $display("FAIL press_data: got %h expected %h", avs_readdata, 32'h4);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL press_irq: got %b expected 1", irq);
        else pass_cnt++;
      end
    end
    avs_read = 1'b0;
    rd(2'd3, d);
    total_cnt++;
    if (d !== 32'h4) $display("FAIL press_edge: got %h expected %h", d, 32'h4);
    else pass_cnt++;
    key_in = 4'hF;
    settle(12);
    clear_all();
    rd(2'd3, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL press_edge_cleared: got %h expected %h", d, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL press_irq_cleared: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    logic        irq_seen;
    irq_seen = 1'b0;
    wr(2'd1, 32'h1);
    repeat (5) begin
      key_in[0] = 1'b0;
      repeat (7) begin
        step();
        if (irq !== 1'b0) irq_seen = 1'b1;
      end
      key_in[0] = 1'b1;
      step();
      if (irq !== 1'b0) irq_seen = 1'b1;
    end
    repeat (12) begin
      step();
      if (irq !== 1'b0) irq_seen = 1'b1;
    end
    total_cnt++;
    if (irq_seen !== 1'b0) $display("FAIL bounce_irq: got %b expected 0", irq_seen);
    else pass_cnt++;
    rd(2'd0, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL bounce_data: got %h expected %h", d, 32'h0);
    else pass_cnt++;
    rd(2'd3, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL bounce_edge: got %h expected %h", d, 32'h0);
    else pass_cnt++;
    wr(2'd1, 32'h0);
  endtask

  task automatic test_w1c_set_wins();
    logic [31:0] d;
    key_in = 4'b1100;
    settle(12);
    rd(2'd3, d);
    total_cnt++;
    if (d !== 32'h3) $display("FAIL w1c_edge_init: got %h expected %h", d, 32'h3);
    else pass_cnt++;
    wr(2'd3, 32'h1);
    rd(2'd3, d);
    total_cnt++;
    if (d !== 32'h2) $display("FAIL w1c_first: got %h expected %h", d, 32'h2);
    else pass_cnt++;
    wr(2'd1, 32'h2);
    key_in[1] = 1'b1;
    settle(12);
    wr(2'd2, 32'hF);
    settle(2);
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL w1c_irq_before: got %b expected 1", irq);
    else pass_cnt++;
    key_in[1] = 1'b0;
    settle(9);
    avs_address   = 2'd3;
    avs_writedata = 32'h2;
    avs_write     = 1'b1;
    step();
    avs_write = 1'b0;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL setwins_irq_0: got %b expected 1", irq);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL setwins_irq_1: got %b expected 1", irq);
    else pass_cnt++;
    rd(2'd3, d);
    total_cnt++;
    if (d !== 32'h2) $display("FAIL setwins_edge: got %h expected %h", d, 32'h2);
    else pass_cnt++;
    key_in = 4'hF;
    settle(12);
    clear_all();
  endtask

  task automatic test_reset_mid_debounce();
    logic [31:0] d;
    wr(2'd1, 32'hF);
    key_in[3] = 1'b0;
    settle(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if (avs_readdata !== 32'h0) $display("FAIL rstmid_readdata: got %h expected %h", avs_readdata, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL rstmid_irq: got %b expected 0", irq);
    else pass_cnt++;
    avs_read = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      avs_address = (i <= 4) ? 2'(i - 1) : 2'd0;
      step();
      if (i <= 4) begin
        total_cnt++;
        if (avs_readdata !== 32'h0) $display("FAIL rstmid_reg%0d: got %h expected %h", i - 1, avs_readdata, 32'h0);
        else pass_cnt++;
      end
      if (i == 10) begin
        total_cnt++;
        if (avs_readdata !== 32'h0) $display("FAIL rstmid_data_early: got %h expected %h", avs_readdata, 32'h0);
        else pass_cnt++;
      end
      if (i == 11) begin
        total_cnt++;
        if (avs_readdata !== 32'h8) $display("FAIL rstmid_data: got %h expected %h", avs_readdata, 32'h8);
        else pass_cnt++;
      end
    end
    avs_read = 1'b0;
    rd(2'd1, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL rstmid_mask: got %h expected %h", d, 32'h0);
    else pass_cnt++;
    key_in = 4'hF;
    settle(12);
    clear_all();
  endtask

  task automatic test_release();
    logic [31:0] d;
    logic [31:0] exp_rel;
`ifdef KEY_CAPTURE_PIO_RELEASE_EN
    exp_rel = 32'h2;
`else
    exp_rel = 32'h0;
`endif
    key_in[1] = 1'b0;
    settle(20);
    key_in[1] = 1'b1;
    avs_address = 2'd2;
    avs_read    = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 10) begin
        total_cnt++;
        if (avs_readdata !== 32'h0) $display("FAIL release_early: got %h expected %h", avs_readdata, 32'h0);
        else pass_cnt++;
      end
      if (i == 11) begin
        total_cnt++;
        if (avs_readdata !== exp_rel) $display("FAIL release_value: got %h expected %h", avs_readdata, exp_rel);
        else pass_cnt++;
      end
    end
    avs_read = 1'b0;
    wr(2'd2, 32'h2);
    rd(2'd2, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL release_w1c: got %h expected %h", d, 32'h0);
    else pass_cnt++;
    clear_all();
  endtask

  task automatic test_multi_key();
    logic [31:0] d;
    key_in = 4'h0;
    avs_read = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      avs_address = (i == 12) ? 2'd3 : 2'd0;
      step();
      if (i == 10) begin
        total_cnt++;
        if (avs_readdata !== 32'h0) $display("FAIL multi_data_early: got %h expected %h", avs_readdata, 32'h0);
        else pass_cnt++;
      end
      if (i == 11) begin
        total_cnt++;
        if (avs_readdata !== 32'h0000_000F) $display("FAIL multi_data: got %h expected %h", avs_readdata, 32'h0000_000F);
        else pass_cnt++;
      end
      if (i == 12) begin
        total_cnt++;
        if (avs_readdata !== 32'h0000_000F) $display("FAIL multi_edge: got %h expected %h", avs_readdata, 32'h0000_000F);
        else pass_cnt++;
      end
    end
    avs_read = 1'b0;
    wr(2'd0, 32'h0);
    rd(2'd0, d);
    total_cnt++;
    if (d !== 32'hF) $display("FAIL data_readonly: got %h expected %h", d, 32'hF);
    else pass_cnt++;
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, d);
    total_cnt++;
    if (d !== 32'hF) $display("FAIL mask_width: got %h expected %h", d, 32'hF);
    else pass_cnt++;
    avs_address   = 2'd3;
    avs_writedata = 32'hF;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    step();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    total_cnt++;
    if (avs_readdata !== 32'hF) $display("FAIL rdwr_prewrite: got %h expected %h", avs_readdata, 32'hF);
    else pass_cnt++;
    rd(2'd3, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL rdwr_cleared: got %h expected %h", d, 32'h0);
    else pass_cnt++;
    step();
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL multi_irq_cleared: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  initial begin
    reset         = 1'b1;
    key_in        = 4'hF;
    avs_address   = 2'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
    test_reset();
    test_press();
    test_bounce();
    test_w1c_set_wins();
    test_reset_mid_debounce();
    test_release();
    test_multi_key();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
